det_seq: RTL and testbench
==========================

# det_seq

Parametrised, sequential signed determinant unit for the matrix coprocessor, succeeding the fixed 8-bit combinational 3x3 determinant. It accepts a packed 3x3 matrix with a start pulse and selects 2x2 or 3x3 mode per operation. One signed term is accumulated per clock into a full-width accumulator. It returns the result with a done pulse, both full-width and narrowed to element width, with a selectable saturate or wrap policy and an overflow flag.

## Interface
- `DW`, default 8: element width, signed two's complement, DW ≥ 2.
- `SAT`, default 1: narrowing policy. 1 saturates `det` to [-2^(DW-1), 2^(DW-1)-1]; 0 wraps to the low DW bits.
- `ACC_W` (localparam) = 3*DW+3: accumulator and `det_full` width.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `size3`  in  1  1 = 3x3, 0 = 2x2 (uses a00, a01, a10, a11 only); latched with `start`.
- `m`  in  9*DW  row-major matrix, a00 at [9*DW-1 -: DW], a22 at [DW-1:0]; latched with `start`.
- `busy`  out  1  high while an operation is in progress.
- `done`  out  1  one-cycle pulse when results update.
- `det`  out  DW  narrowed determinant.
- `det_full`  out  ACC_W  exact signed determinant.
- `ovf`  out  1  exact result outside the signed DW range.

## Operation
- States:
  - IDLE: `start`=1 latches `m` and `size3`, clears the accumulator, sets idx=0, goes to CALC.
  - CALC: adds one signed term per cycle and increments idx.
  - On the last term, goes back to IDLE (no separate DONE state).
- 3x3 term order and signs:
  - idx 0 +a00·a11·a22
  - idx 1 +a01·a12·a20
  - idx 2 +a02·a10·a21
  - idx 3 −a02·a11·a20
  - idx 4 −a00·a12·a21
  - idx 5 −a01·a10·a22
- 2x2 terms: idx 0 +a00·a11, idx 1 −a01·a10.
- All products and sums are signed and sign-extended to ACC_W; no intermediate truncation occurs.
- Result write happens at the edge that adds the last term, using acc+term:
  - `det_full` = exact sum.
  - `ovf` = (sum > 2^(DW-1)-1) or (sum < −2^(DW-1)).
  - `det`: SAT=1 clamps to the nearest bound when `ovf`, else takes the low DW bits; SAT=0 always takes the low DW bits.
- `det`, `det_full` and `ovf` hold their value until the next completion or reset.
- Input changes on `m` or `size3` while busy have no effect; the latched copy is used.
- `start` while busy is ignored and not queued.

## Timing
- Reset (`rst_n`=0, asynchronous, any state): IDLE, idx=0, accumulator=0, `busy`=0, `done`=0, `det`=0, `det_full`=0, `ovf`=0. Operation resumes on the first edge after release.
- Edge E0 samples `start`=1 in IDLE; `busy`=1 from after E0.
- 3x3: terms are added at E1..E6. Results are valid and `done`=1 after E6, with `busy`=0 in the same cycle.
- 2x2: terms are added at E1..E2; results and `done` follow E2.
- Latency is 6 cycles (3x3) or 2 cycles (2x2) from the start edge; throughput is one operation per 7 or 3 cycles.
- `start`=1 during the `done` cycle is accepted (state is IDLE), giving back-to-back operation.
- `done` lasts exactly one cycle and drops on the next edge regardless of `start`.
- Reset asserted mid-CALC aborts the operation. No `done` is produced and outputs read 0.

## Test plan
- Identity 3x3, DW=8, SAT=1 → `done` 6 cycles after start; `det`=1, `det_full`=1, `ovf`=0.
- 3x3 [[2,0,0],[0,3,0],[0,0,4]] → `det`=24. Then [[1,2,3],[4,5,6],[7,8,10]] → `det`=−3, `ovf`=0.
- diag(10,10,10):
  - SAT=1 → `det_full`=1000, `det`=127, `ovf`=1.
  - SAT=0 → `det`=−24, `ovf`=1.
  - diag(−128,−128,−128) with SAT=1 → `det_full`=−2097152, `det`=−128, `ovf`=1.
- 2x2, `size3`=0, a00=3, a01=−2, a10=5, a11=4 (other elements nonzero garbage) → `done` 2 cycles after start, `det`=22.
- `start` pulsed at busy cycle 3 with a different `m` → ignored, first result unchanged. `start` held in the `done` cycle → second operation starts and completes 6 cycles later.
- `rst_n` low during CALC idx 3 → `busy`, `done`, `det`, `det_full`, `ovf` read 0 with no `done` pulse. A new start after release yields the correct result.

Source files
------------

// File: rtl/det_seq.sv
// Sequential signed determinant for 2x2 or 3x3 matrices. One product term is
// accumulated per clock into a full-width accumulator, then narrowed on completion.
//
// state | meaning
// IDLE  | waiting for start; results hold their last value
// CALC  | accumulating one signed term per cycle, idx selects the term
module det_seq #(
    parameter int DW  = 8,
    parameter int SAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                size3,
    input  logic [9*DW-1:0]     m,
    output logic                busy,
    output logic                done,
    output logic [DW-1:0]       det,
    output logic [3*DW+2:0]     det_full,
    output logic                ovf
);

    localparam int ACC_W = 3*DW+3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_CALC = 1'b1;

    logic [0:0]              state;
    logic [2:0]              idx;
    logic                    size3_q;
    logic [9*DW-1:0]         m_q;
    logic signed [ACC_W-1:0] acc;

    logic signed [DW-1:0]    a [9];
    logic signed [DW-1:0]    f0, f1, f2;
    logic                    neg;
    logic signed [ACC_W-1:0] e0, e1, e2, prod, term, sum;
    logic signed [ACC_W-1:0] max_v, min_v;
    logic                    last_term, ovf_nx;
    logic [DW-1:0]           det_nx;

    always_comb begin
        for (int i = 0; i < 9; i++) begin
            a[i] = m_q[(9-i)*DW-1 -: DW];
        end
    end

    // Term table: three positive diagonals first, then the three negative ones.
    always_comb begin
        f0  = '0;
        f1  = '0;
        f2  = '0;
        neg = 1'b0;
        if (size3_q) begin
            case (idx)
                3'd0: begin f0 = a[0]; f1 = a[4]; f2 = a[8]; end
                3'd1: begin f0 = a[1]; f1 = a[5]; f2 = a[6]; end
                3'd2: begin f0 = a[2]; f1 = a[3]; f2 = a[7]; end
                3'd3: begin f0 = a[2]; f1 = a[4]; f2 = a[6]; neg = 1'b1; end
                3'd4: begin f0 = a[0]; f1 = a[5]; f2 = a[7]; neg = 1'b1; end
                3'd5: begin f0 = a[1]; f1 = a[3]; f2 = a[8]; neg = 1'b1; end
                default: ;
            endcase
        end else begin
            case (idx)
                3'd0: begin f0 = a[0]; f1 = a[4]; end
                3'd1: begin f0 = a[1]; f1 = a[3]; neg = 1'b1; end
                default: ;
            endcase
        end
    end

    always_comb begin
        e0    = {{(ACC_W-DW){f0[DW-1]}}, f0};
        e1    = {{(ACC_W-DW){f1[DW-1]}}, f1};
        e2    = size3_q ? {{(ACC_W-DW){f2[DW-1]}}, f2} : {{(ACC_W-1){1'b0}}, 1'b1};
        prod  = e0 * e1 * e2;
        term  = neg ? -prod : prod;
        sum   = acc + term;
        max_v = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
        min_v = ~max_v;
        last_term = size3_q ? (idx == 3'd5) : (idx == 3'd1);
        ovf_nx    = (sum > max_v) || (sum < min_v);
        if ((SAT != 0) && ovf_nx) begin
            det_nx = sum[ACC_W-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end else begin
            det_nx = sum[DW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            size3_q  <= 1'b0;
            m_q      <= '0;
            acc      <= '0;
            done     <= 1'b0;
            det      <= '0;
            det_full <= '0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        m_q     <= m;
                        size3_q <= size3;
                        acc     <= '0;
                        idx     <= '0;
                        state   <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    acc <= sum;
                    if (last_term) begin
                        state    <= ST_IDLE;
                        idx      <= '0;
                        det_full <= sum;
                        det      <= det_nx;
                        ovf      <= ovf_nx;
                        done     <= 1'b1;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state == ST_CALC);

endmodule

// File: tb/tb_det_seq.sv
// Scoreboard bench for det_seq: a saturating and a wrapping instance share stimulus;
// expected results are computed by cofactor expansion and queued at each start.
module tb_det_seq;

    localparam int DW    = 8;
    localparam int ACC_W = 3*DW+3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              size3 = 1'b1;
    logic [9*DW-1:0]   m = '0;

    logic              busy_s, done_s, ovf_s, busy_w, done_w, ovf_w;
    logic [DW-1:0]     det_s, det_w;
    logic [ACC_W-1:0]  full_s, full_w;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        longint     full;
        logic [7:0] dsat;
        logic [7:0] dwrap;
        logic       ovf;
    } exp_t;

    exp_t exp_q[$];

    det_seq #(.DW(DW), .SAT(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start), .size3(size3), .m(m),
        .busy(busy_s), .done(done_s), .det(det_s), .det_full(full_s), .ovf(ovf_s)
    );

    det_seq #(.DW(DW), .SAT(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .size3(size3), .m(m),
        .busy(busy_w), .done(done_w), .det(det_w), .det_full(full_w), .ovf(ovf_w)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input int e[9], input logic s3);
        exp_t   r;
        longint v;
        longint a0, a1, a2, a3, a4, a5, a6, a7, a8;
        a0 = e[0]; a1 = e[1]; a2 = e[2]; a3 = e[3]; a4 = e[4];
        a5 = e[5]; a6 = e[6]; a7 = e[7]; a8 = e[8];
        if (s3) v = a0*(a4*a8 - a5*a7) - a1*(a3*a8 - a5*a6) + a2*(a3*a7 - a4*a6);
        else    v = a0*a4 - a1*a3;
        r.full  = v;
        r.ovf   = (v > 127) || (v < -128);
        r.dwrap = v[7:0];
        r.dsat  = r.ovf ? ((v < 0) ? 8'h80 : 8'h7f) : v[7:0];
        return r;
    endfunction

    // Called #1 after an edge; returns #1 after the start edge E0.
    task automatic launch(input int e[9], input logic s3, input bit push);
        for (int i = 0; i < 9; i++) m[(9-i)*DW-1 -: DW] = e[i][7:0];
        size3 = s3;
        start = 1'b1;
        if (push) exp_q.push_back(model(e, s3));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit timed_out);
        lat = 0;
        timed_out = 1'b1;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (done_s) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({busy_s, done_s, ovf_s, det_s, full_s} !== '0) begin
            n_fail++;
            $display("FAIL reset_sat: got busy=%b done=%b ovf=%b det=%0d full=%0d, want all 0",
                     busy_s, done_s, ovf_s, det_s, full_s);
        end
        n_cmp++;
        if ({busy_w, done_w, ovf_w, det_w, full_w} !== '0) begin
            n_fail++;
            $display("FAIL reset_wrap: got busy=%b done=%b ovf=%b det=%0d full=%0d, want all 0",
                     busy_w, done_w, ovf_w, det_w, full_w);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (busy_s !== 1'b0 || done_s !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy_s, done_s);
        end
    endtask

    task automatic test_ops();
        int   ops [6][9];
        logic s3s [6];
        int   lats [6];
        int   cur [9];
        int   lat;
        bit   to;
        exp_t ex;
        ops = '{'{1, 0, 0, 0, 1, 0, 0, 0, 1},
                '{2, 0, 0, 0, 3, 0, 0, 0, 4},
                '{1, 2, 3, 4, 5, 6, 7, 8, 10},
                '{10, 0, 0, 0, 10, 0, 0, 0, 10},
                '{-128, 0, 0, 0, -128, 0, 0, 0, -128},
                '{3, -2, 77, 5, 4, -99, 55, 66, -11}};
        s3s  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        lats = '{6, 6, 6, 6, 6, 2};
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 9; j++) cur[j] = ops[i][j];
            launch(cur, s3s[i], 1'b1);
            n_cmp++;
            if (busy_s !== 1'b1) begin
                n_fail++;
                $display("FAIL op%0d_busy: got %b, want 1", i, busy_s);
            end
            wait_done(lat, to);
            n_cmp++;
            if (to || lat != lats[i]) begin
                n_fail++;
                $display("FAIL op%0d_latency: got %0d (timeout=%0d), want %0d", i, lat, to, lats[i]);
            end
            ex = exp_q.pop_front();
            n_cmp++;
            if ($signed(full_s) != ex.full || $signed(full_w) != ex.full) begin
                n_fail++;
                $display("FAIL op%0d_det_full: got %0d / %0d, want %0d", i,
                         $signed(full_s), $signed(full_w), ex.full);
            end
            n_cmp++;
            if (det_s !== ex.dsat || det_w !== ex.dwrap) begin
                n_fail++;
                $display("FAIL op%0d_det: got sat=%0d wrap=%0d, want sat=%0d wrap=%0d", i,
                         $signed(det_s), $signed(det_w), $signed(ex.dsat), $signed(ex.dwrap));
            end
            n_cmp++;
            if (ovf_s !== ex.ovf || ovf_w !== ex.ovf || busy_s !== 1'b0) begin
                n_fail++;
                $display("FAIL op%0d_ovf_busy: got ovf=%b/%b busy=%b, want ovf=%b busy=0", i,
                         ovf_s, ovf_w, busy_s, ex.ovf);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (done_s !== 1'b0) begin
                n_fail++;
                $display("FAIL op%0d_done_width: got done=%b one cycle later, want 0", i, done_s);
            end
        end
    endtask

    task automatic test_ignore_start();
        int   ga [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 10};
        int   lat;
        bit   to;
        int   pulses;
        exp_t ex;
        launch(ga, 1'b1, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        m = {8'd10, 8'd0, 8'd0, 8'd0, 8'd10, 8'd0, 8'd0, 8'd0, 8'd10};
        size3 = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_cmp++;
        if (busy_s !== 1'b1 || done_s !== 1'b0) begin
            n_fail++;
            $display("FAIL ignore_busy: got busy=%b done=%b, want 1 0", busy_s, done_s);
        end
        wait_done(lat, to);
        n_cmp++;
        if (to || lat != 3) begin
            n_fail++;
            $display("FAIL ignore_latency: got %0d remaining (timeout=%0d), want 3", lat, to);
        end
        ex = exp_q.pop_front();
        n_cmp++;
        if ($signed(full_s) != ex.full || det_s !== ex.dsat || ovf_s !== ex.ovf) begin
            n_fail++;
            $display("FAIL ignore_result: got full=%0d det=%0d ovf=%b, want %0d %0d %b",
                     $signed(full_s), $signed(det_s), ovf_s, ex.full, $signed(ex.dsat), ex.ovf);
        end
        pulses = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (done_s || busy_s) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL ignore_not_queued: got %0d active cycles, want 0", pulses);
        end
    endtask

    task automatic test_back_to_back();
        int   da [9] = '{2, 0, 0, 0, 3, 0, 0, 0, 4};
        int   ga [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 10};
        int   lat;
        bit   to;
        exp_t ex;
        launch(da, 1'b1, 1'b1);
        wait_done(lat, to);
        ex = exp_q.pop_front();
        n_cmp++;
        if (to || $signed(full_s) != ex.full || det_s !== ex.dsat) begin
            n_fail++;
            $display("FAIL b2b_first: got full=%0d det=%0d timeout=%0d, want %0d %0d",
                     $signed(full_s), $signed(det_s), to, ex.full, $signed(ex.dsat));
        end
        launch(ga, 1'b1, 1'b1);
        n_cmp++;
        if (busy_s !== 1'b1 || done_s !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: got busy=%b done=%b, want 1 0", busy_s, done_s);
        end
        wait_done(lat, to);
        ex = exp_q.pop_front();
        n_cmp++;
        if (to || lat != 6 || $signed(full_s) != ex.full || det_s !== ex.dsat) begin
            n_fail++;
            $display("FAIL b2b_second: got lat=%0d full=%0d det=%0d timeout=%0d, want 6 %0d %0d",
                     lat, $signed(full_s), $signed(det_s), to, ex.full, $signed(ex.dsat));
        end
    endtask

    task automatic test_reset_mid();
        int   ia [9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        int   ga [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 10};
        int   lat;
        bit   to;
        int   pulses;
        exp_t ex;
        launch(ia, 1'b1, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy_s, done_s, ovf_s, det_s, full_s} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs: got busy=%b done=%b ovf=%b det=%0d full=%0d, want all 0",
                     busy_s, done_s, ovf_s, det_s, full_s);
        end
        pulses = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done_s) pulses++;
            if (pulses == 0 && rst_n == 1'b0) rst_n = 1'b1;
        end
        n_cmp++;
        if (pulses != 0 || busy_s !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d pulses busy=%b, want 0 0", pulses, busy_s);
        end
        launch(ga, 1'b1, 1'b1);
        wait_done(lat, to);
        ex = exp_q.pop_front();
        n_cmp++;
        if (to || lat != 6 || $signed(full_s) != ex.full || det_s !== ex.dsat || ovf_s !== ex.ovf) begin
            n_fail++;
            $display("FAIL abort_recover: got lat=%0d full=%0d det=%0d ovf=%b, want 6 %0d %0d %b",
                     lat, $signed(full_s), $signed(det_s), ovf_s, ex.full, $signed(ex.dsat), ex.ovf);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left, want 0", exp_q.size());
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ops();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
